// File: rtl/burst_line_adaptor.sv
// Cache-line to memory-burst adaptor: splits one line read/write into
// LINE_W/BURST_W beats paced by resp_i, with optional critical-word-first reads.
// Ports: clk/rst; cache side read_i, write_i, address_i, line_i -> line_o, resp_o;
// memory side address_o, read_o, write_o, burst_o, burst_i, resp_i.
module burst_line_adaptor #(
  parameter int LINE_W  = 256,
  parameter int BURST_W = 64,
  parameter int ADDR_W  = 32,
  parameter int CWF     = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              read_i,
  input  logic              write_i,
  input  logic [ADDR_W-1:0] address_i,
  input  logic [LINE_W-1:0] line_i,
  output logic [LINE_W-1:0] line_o,
  output logic              resp_o,
  output logic [ADDR_W-1:0] address_o,
  output logic              read_o,
  output logic              write_o,
  output logic [BURST_W-1:0] burst_o,
  input  logic [BURST_W-1:0] burst_i,
  input  logic              resp_i
);

  localparam int BEATS = LINE_W / BURST_W;
  localparam int OFF   = $clog2(BURST_W / 8);
  localparam int LOFF  = $clog2(LINE_W / 8);
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [ADDR_W-1:0] BMASK = {ADDR_W{1'b1}} << OFF;
  localparam logic [ADDR_W-1:0] LMASK = {ADDR_W{1'b1}} << LOFF;
  localparam logic [CW-1:0]     LAST  = CW'(BEATS - 1);
  localparam logic [CW:0]       NB    = (CW+1)'(BEATS);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     start;
  logic [CW-1:0]     istart;
  logic [LINE_W-1:0] wbuf;
  logic [LINE_W-1:0] lbuf;
  logic [CW:0]       sum;
  logic [CW-1:0]     slot;

  // Beat index inside the line picked by the request address (CWF only).
  assign istart = (CWF != 0) ? CW'(address_i >> OFF) : '0;

  // Read slot = (start + k) mod BEATS, valid for any BEATS count.
  assign sum  = {1'b0, start} + {1'b0, cnt};
  assign slot = (sum >= NB) ? CW'(sum - NB) : sum[CW-1:0];

  assign line_o  = lbuf;
  assign burst_o = write_o ? wbuf[cnt*BURST_W +: BURST_W] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      start     <= '0;
      wbuf      <= '0;
      lbuf      <= '0;
      read_o    <= 1'b0;
      write_o   <= 1'b0;
      resp_o    <= 1'b0;
      address_o <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (read_i) begin
            state     <= RD;
            read_o    <= 1'b1;
            start     <= istart;
            wbuf      <= line_i;
            address_o <= (CWF != 0) ? (address_i & BMASK)
                                    : (address_i & LMASK);
          end else if (write_i) begin
            state     <= WR;
            write_o   <= 1'b1;
            start     <= '0;
            wbuf      <= line_i;
            address_o <= address_i & LMASK;
          end
        end
        RD: begin
          if (resp_i) begin
            lbuf[slot*BURST_W +: BURST_W] <= burst_i;
            cnt <= cnt + 1'b1;
            if (cnt == LAST) begin
              read_o    <= 1'b0;
              resp_o    <= 1'b1;
              address_o <= '0;
              cnt       <= '0;
              state     <= DONE;
            end
          end
        end
        WR: begin
          if (resp_i) begin
            cnt <= cnt + 1'b1;
            if (cnt == LAST) begin
              write_o   <= 1'b0;
              resp_o    <= 1'b1;
              address_o <= '0;
              cnt       <= '0;
              state     <= DONE;
            end
          end
        end
        DONE: begin
          resp_o <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_burst_line_adaptor.sv
// Scoreboard bench for burst_line_adaptor: default, CWF=1 and 512/128 builds.
// Stimulus pushes expected completions; a negedge monitor checks each resp_o.
module tb_burst_line_adaptor;

  typedef struct {
    logic         wr;
    logic [511:0] line;
    logic [511:0] keep;
    logic [31:0]  addr;
    int           strobes;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // shared stimulus for the two 256/64 builds
  logic         read_i, write_i, resp_i;
  logic [31:0]  address_i;
  logic [255:0] line_i;
  logic [63:0]  burst_i;

  logic [255:0] a_line_o, b_line_o;
  logic         a_resp_o, b_resp_o, a_read_o, b_read_o, a_write_o, b_write_o;
  logic [31:0]  a_addr_o, b_addr_o;
  logic [63:0]  a_burst_o, b_burst_o;

  // 512/128 build
  logic         c_read_i, c_write_i, c_resp_i;
  logic [31:0]  c_address_i;
  logic [511:0] c_line_i;
  logic [127:0] c_burst_i;
  logic [511:0] c_line_o;
  logic         c_resp_o, c_read_o, c_write_o;
  logic [31:0]  c_addr_o;
  logic [127:0] c_burst_o;

  burst_line_adaptor u_a (
    .clk(clk), .rst(rst), .read_i(read_i), .write_i(write_i),
    .address_i(address_i), .line_i(line_i), .line_o(a_line_o),
    .resp_o(a_resp_o), .address_o(a_addr_o), .read_o(a_read_o),
    .write_o(a_write_o), .burst_o(a_burst_o), .burst_i(burst_i),
    .resp_i(resp_i)
  );

  burst_line_adaptor #(.CWF(1)) u_b (
    .clk(clk), .rst(rst), .read_i(read_i), .write_i(write_i),
    .address_i(address_i), .line_i(line_i), .line_o(b_line_o),
    .resp_o(b_resp_o), .address_o(b_addr_o), .read_o(b_read_o),
    .write_o(b_write_o), .burst_o(b_burst_o), .burst_i(burst_i),
    .resp_i(resp_i)
  );

  burst_line_adaptor #(.LINE_W(512), .BURST_W(128)) u_c (
    .clk(clk), .rst(rst), .read_i(c_read_i), .write_i(c_write_i),
    .address_i(c_address_i), .line_i(c_line_i), .line_o(c_line_o),
    .resp_o(c_resp_o), .address_o(c_addr_o), .read_o(c_read_o),
    .write_o(c_write_o), .burst_o(c_burst_o), .burst_i(c_burst_i),
    .resp_i(c_resp_i)
  );

  logic [511:0] m_line[3];
  logic [127:0] m_burst[3];
  logic [31:0]  m_addr[3];
  logic         m_rd[3], m_wr[3], m_resp[3], m_respi[3];

  assign m_line[0]  = {256'b0, a_line_o};
  assign m_line[1]  = {256'b0, b_line_o};
  assign m_line[2]  = c_line_o;
  assign m_burst[0] = {64'b0, a_burst_o};
  assign m_burst[1] = {64'b0, b_burst_o};
  assign m_burst[2] = c_burst_o;
  assign m_addr[0]  = a_addr_o;
  assign m_addr[1]  = b_addr_o;
  assign m_addr[2]  = c_addr_o;
  assign m_rd[0]    = a_read_o;
  assign m_rd[1]    = b_read_o;
  assign m_rd[2]    = c_read_o;
  assign m_wr[0]    = a_write_o;
  assign m_wr[1]    = b_write_o;
  assign m_wr[2]    = c_write_o;
  assign m_resp[0]  = a_resp_o;
  assign m_resp[1]  = b_resp_o;
  assign m_resp[2]  = c_resp_o;
  assign m_respi[0] = resp_i;
  assign m_respi[1] = resp_i;
  assign m_respi[2] = c_resp_i;

  int tests = 0;
  int fails = 0;

  exp_t q[3][$];

  task automatic chk(input string nm, input logic [511:0] act,
                     input logic [511:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  int           cnt[3];
  int           wn[3];
  logic [511:0] wcap[3];
  logic         prev[3];
  exp_t         me;

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        cnt[i]  = 0;
        wn[i]   = 0;
        wcap[i] = '0;
        prev[i] = 1'b0;
      end else begin
        chk($sformatf("overlap%0d", i),
            512'(int'(m_rd[i]) + int'(m_wr[i]) + int'(m_resp[i]) > 1), 0);
        if (m_rd[i] || m_wr[i]) begin
          cnt[i]++;
          if (q[i].size() > 0)
            chk($sformatf("addr%0d", i), m_addr[i], q[i][0].addr);
          if (m_wr[i] && m_respi[i]) begin
            wcap[i] = wcap[i] |
              ({384'b0, m_burst[i]} << (wn[i] * ((i == 2) ? 128 : 64)));
            wn[i]++;
          end
        end
        if (m_resp[i]) begin
          chk($sformatf("resp_len%0d", i), 512'(prev[i]), 0);
          if (q[i].size() == 0) begin
            chk($sformatf("spurious_resp%0d", i), 1, 0);
          end else begin
            me = q[i].pop_front();
            chk($sformatf("strobes%0d", i), cnt[i], me.strobes);
            if (me.wr) begin
              chk($sformatf("wbeats%0d", i), wcap[i], me.line);
              chk($sformatf("line_keep%0d", i), m_line[i], me.keep);
            end else begin
              chk($sformatf("rline%0d", i), m_line[i], me.line);
            end
          end
          cnt[i]  = 0;
          wn[i]   = 0;
          wcap[i] = '0;
        end
        prev[i] = m_resp[i];
      end
    end
  end

  // ---------------- stimulus ----------------
  localparam logic [63:0] BA = 64'hA1A1_0000_0000_000A;
  localparam logic [63:0] BB = 64'hB2B2_0000_0000_000B;
  localparam logic [63:0] BC = 64'hC3C3_0000_0000_000C;
  localparam logic [63:0] BD = 64'hD4D4_0000_0000_000D;
  localparam logic [63:0] BE = 64'hE5E5_1111_0000_000E;
  localparam logic [63:0] BF = 64'hF6F6_2222_0000_000F;
  localparam logic [63:0] BG = 64'h0707_3333_0000_0010;
  localparam logic [63:0] BH = 64'h1818_4444_0000_0011;
  localparam logic [63:0] BP = 64'h5050_AAAA_5555_0001;
  localparam logic [63:0] BQ = 64'h5151_AAAA_5555_0002;
  localparam logic [63:0] BR = 64'h5252_AAAA_5555_0003;
  localparam logic [63:0] BS = 64'h5353_AAAA_5555_0004;

  logic [255:0] last_a, last_b;
  logic [511:0] last_c;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // d: write line, or read beats in arrival order (beat k = d[k*64 +: 64])
  task automatic ab_txn(input logic wr, input logic [31:0] a,
                        input logic [255:0] d, input int gpos, input int glen,
                        input logic [255:0] ea, input logic [255:0] eb,
                        input logic [31:0] aa, input logic [31:0] ab);
    exp_t e;
    e.wr = wr; e.strobes = 4 + glen;
    e.line = wr ? {256'b0, d} : {256'b0, ea};
    e.keep = {256'b0, last_a}; e.addr = aa;
    q[0].push_back(e);
    e.line = wr ? {256'b0, d} : {256'b0, eb};
    e.keep = {256'b0, last_b}; e.addr = ab;
    q[1].push_back(e);
    if (!wr) begin last_a = ea; last_b = eb; end
    read_i = !wr; write_i = wr; address_i = a; line_i = d;
    tick();
    for (int k = 0; k < 4; k++) begin
      if (k == gpos)
        for (int g = 0; g < glen; g++) begin resp_i = 1'b0; tick(); end
      resp_i = 1'b1; burst_i = d[k*64 +: 64];
      tick();
    end
    resp_i = 1'b0; read_i = 1'b0; write_i = 1'b0; burst_i = '0;
    tick();
    tick();
  endtask

  task automatic c_txn(input logic wr, input logic [31:0] a,
                       input logic [511:0] d);
    exp_t e;
    int gl[4];
    int tot;
    tot = 0;
    for (int k = 0; k < 4; k++) begin
      gl[k] = $urandom_range(0, 2);
      tot += gl[k];
    end
    e.wr = wr; e.strobes = 4 + tot; e.line = d; e.keep = last_c;
    e.addr = a & 32'hFFFF_FFC0;
    q[2].push_back(e);
    if (!wr) last_c = d;
    c_read_i = !wr; c_write_i = wr; c_address_i = a; c_line_i = d;
    tick();
    for (int k = 0; k < 4; k++) begin
      for (int g = 0; g < gl[k]; g++) begin c_resp_i = 1'b0; tick(); end
      c_resp_i = 1'b1; c_burst_i = d[k*128 +: 128];
      tick();
    end
    c_resp_i = 1'b0; c_read_i = 1'b0; c_write_i = 1'b0; c_burst_i = '0;
    tick();
    tick();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic         wr;
    logic [31:0]  a;
    logic [511:0] d;
    rst = 1'b1;
    read_i = 0; write_i = 0; resp_i = 0; address_i = 0; line_i = 0;
    burst_i = 0;
    c_read_i = 0; c_write_i = 0; c_resp_i = 0; c_address_i = 0;
    c_line_i = 0; c_burst_i = 0;
    last_a = '0; last_b = '0; last_c = '0;
    tick();
    tick();
    chk("rst_outs_a", {a_read_o, a_write_o, a_resp_o, a_addr_o, a_burst_o}, 0);
    chk("rst_line_a", a_line_o, 0);
    chk("rst_outs_c", {c_read_o, c_write_o, c_resp_o, c_addr_o, c_burst_o}, 0);
    chk("rst_line_c", c_line_o, 0);
    rst = 1'b0;
    tick();

    // 1: plain read, no waits
    ab_txn(0, 32'h0000_1234, {BD, BC, BB, BA}, 0, 0,
           {BD, BC, BB, BA}, {BB, BA, BD, BC},
           32'h0000_1220, 32'h0000_1230);
    // 2: seven wait cycles before the first beat
    ab_txn(0, 32'h0000_1234, {BH, BG, BF, BE}, 0, 7,
           {BH, BG, BF, BE}, {BF, BE, BH, BG},
           32'h0000_1220, 32'h0000_1230);
    // 3: critical-word-first from beat 2
    ab_txn(0, 32'h0000_0010, {BD, BC, BB, BA}, 0, 0,
           {BD, BC, BB, BA}, {BB, BA, BD, BC},
           32'h0000_0000, 32'h0000_0010);
    // 4: write with a one-cycle gap after beat 1
    ab_txn(1, 32'h0000_1234, {64'd3, 64'd2, 64'd1, 64'd0}, 2, 1,
           '0, '0, 32'h0000_1220, 32'h0000_1220);

    // 6: reset after three beats of a read
    read_i = 1'b1; address_i = 32'h0000_0040;
    tick();
    for (int k = 0; k < 3; k++) begin
      resp_i = 1'b1; burst_i = 64'hDEAD_0000_0000_0000 + 64'(k);
      tick();
    end
    rst = 1'b1; resp_i = 1'b0; read_i = 1'b0;
    #1;
    chk("abort_strobe_a", {a_read_o, a_write_o, a_resp_o}, 0);
    chk("abort_strobe_b", {b_read_o, b_write_o, b_resp_o}, 0);
    chk("abort_line_a", a_line_o, 0);
    last_a = '0; last_b = '0; last_c = '0;
    tick();
    rst = 1'b0;
    tick();
    tick();
    ab_txn(0, 32'h0000_0008, {BS, BR, BQ, BP}, 0, 0,
           {BS, BR, BQ, BP}, {BR, BQ, BP, BS},
           32'h0000_0000, 32'h0000_0008);

    // 5: 512/128 mixed traffic
    for (int n = 0; n < 50; n++) begin
      wr = 1'($urandom_range(0, 1));
      a = $urandom;
      for (int j = 0; j < 16; j++) d[j*32 +: 32] = $urandom;
      c_txn(wr, a, d);
    end

    for (int t = 0; t < 100 &&
         (q[0].size() + q[1].size() + q[2].size()) > 0; t++)
      tick();
    chk("drain", q[0].size() + q[1].size() + q[2].size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
